uart_tx_sched: RTL and testbench

Round-robin scheduler that shares one `uart_transmitter` among `N` byte sources. It arbitrates among requesting sources and holds the grant for the length of a multi-byte packet. It hands one byte at a time to the transmitter through a single-cycle `req` pulse and waits for `next_tx` before serving the next byte. It also owns the transmitter configuration: it drives `tr_en` and a baud compare value that is only updated while idle.

---
 rtl/uart_tx_sched.sv | 108 ++++++++++
 tb/tb_uart_tx_sched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART transmitter among N byte sources
module uart_tx_sched #(
    parameter int N = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           cfg_en_i,
    input  logic [15:0]    cfg_comp_i,
    input  logic [N-1:0]   src_req_i,
    input  logic [N-1:0]   src_last_i,
    input  logic [N*8-1:0] src_data_i,
    output logic [N-1:0]   src_ack_o,
    output logic           tr_en_o,
    output logic [15:0]    comp_o,
    output logic [7:0]     tx_data_o,
    output logic           req_o,
    input  logic           next_tx_i,
    output logic           busy_o,
    output logic [2:0]     grant_id_o,
    output logic           locked_o,
    output logic           abort_o
);
    typedef enum logic {S_ARB, S_WAIT} state_t;
    state_t       state_q, state_d;
    logic [N-1:0] ack_q, ack_d, cand, cand_sh;
    logic [15:0]  comp_q, comp_d;
    logic [7:0]   tx_q, tx_d;
    logic         req_q, req_d, locked_q, locked_d, abort_q, abort_d, found;
    logic [2:0]   grant_q, grant_d, win, idx;

    // Round-robin pick from the source after the last grant; an open packet narrows candidates to its owner
    always_comb begin
        cand = locked_q ? (src_req_i & (N'(1) << grant_q)) : src_req_i;
        found = 1'b0;
        win = grant_q;
        idx = '0;
        cand_sh = '0;
        for (int k = 1; k <= N; k++) begin
            idx = 3'((int'(grant_q) + k) % N);
            cand_sh = cand >> idx;
            if (!found && cand_sh[0]) begin
                found = 1'b1;
                win = idx;
            end
        end
    end

    // Next state: disable overrides everything, compare value only tracks software while idle and unlocked
    always_comb begin
        state_d = state_q;
        req_d = 1'b0;
        ack_d = '0;
        tx_d = tx_q;
        grant_d = grant_q;
        locked_d = locked_q;
        abort_d = 1'b0;
        comp_d = (state_q == S_ARB && !locked_q) ? cfg_comp_i : comp_q;
        if (!cfg_en_i) begin
            state_d = S_ARB;
            locked_d = 1'b0;
            abort_d = (state_q == S_WAIT) && !next_tx_i;
        end else if (state_q == S_ARB) begin
            if (found) begin
                tx_d = src_data_i[8*int'(win) +: 8];
                req_d = 1'b1;
                ack_d = N'(1) << win;
                grant_d = win;
                locked_d = ~src_last_i[win];
                state_d = S_WAIT;
            end
        end else if (next_tx_i) begin
            state_d = S_ARB;
        end
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_ARB;
            req_q <= 1'b0;
            ack_q <= '0;
            tx_q <= '0;
            comp_q <= '0;
            grant_q <= 3'(N - 1);
            locked_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q <= req_d;
            ack_q <= ack_d;
            tx_q <= tx_d;
            comp_q <= comp_d;
            grant_q <= grant_d;
            locked_q <= locked_d;
            abort_q <= abort_d;
        end
    end

    assign src_ack_o  = ack_q;
    assign tr_en_o    = cfg_en_i;
    assign comp_o     = comp_q;
    assign tx_data_o  = tx_q;
    assign req_o      = req_q;
    assign busy_o     = state_q == S_WAIT;
    assign grant_id_o = grant_q;
    assign locked_o   = locked_q;
    assign abort_o    = abort_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed and random checks of the scheduler against a queue-based source/transmitter model
module tb_uart_tx_sched;
    localparam int N = 4;
    logic           clk = 1'b0, rst, cfg_en, next_tx;
    logic [15:0]    cfg_comp, comp;
    logic [N-1:0]   src_req, src_last, src_ack;
    logic [N*8-1:0] src_data;
    logic           tr_en, req, busy, locked, abort;
    logic [7:0]     tx_data;
    logic [2:0]     grant_id;

    always #5 clk = ~clk;

    uart_tx_sched #(.N(N)) dut (
        .clk_i(clk), .rst_i(rst), .cfg_en_i(cfg_en), .cfg_comp_i(cfg_comp),
        .src_req_i(src_req), .src_last_i(src_last), .src_data_i(src_data),
        .src_ack_o(src_ack), .tr_en_o(tr_en), .comp_o(comp), .tx_data_o(tx_data),
        .req_o(req), .next_tx_i(next_tx), .busy_o(busy), .grant_id_o(grant_id),
        .locked_o(locked), .abort_o(abort)
    );

    int errors = 0, checks = 0, cyc = 0;
    logic [7:0] dq [N][$];
    bit         lq [N][$];
    int         ack_log [$];
    bit         m_busy, m_locked;
    int         m_grant;
    logic [15:0] m_comp;
    logic [7:0]  m_tx;
    int timer = 0, dly = 10, last_nt = -100;
    bit nt_pend = 0, force_nt = 0, gap_chk = 0;
    int rr_exp [5] = '{0, 1, 2, 3, 0};
    int pk_exp [4] = '{2, 2, 2, 3};
    int ab_exp [3] = '{1, 2, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input int s, input logic [7:0] d, input bit last);
        dq[s].push_back(d);
        lq[s].push_back(last);
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (dq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    // Who should win next: the locked owner if it has a byte, else the first waiting source after the last grant
    function automatic int pick();
        if (m_locked) return (dq[m_grant].size() > 0) ? m_grant : -1;
        for (int k = 1; k <= N; k++) if (dq[(m_grant + k) % N].size() > 0) return (m_grant + k) % N;
        return -1;
    endfunction

    task automatic drive();
        next_tx = nt_pend | force_nt;
        for (int i = 0; i < N; i++) begin
            src_req[i] = dq[i].size() > 0;
            src_data[i*8 +: 8] = (dq[i].size() > 0) ? dq[i][0] : 8'($urandom);
            src_last[i] = (dq[i].size() > 0) ? lq[i][0] : 1'($urandom);
        end
    endtask

    task automatic tick();
        int w;
        logic e_req, e_abort;
        logic [N-1:0] e_ack;
        logic [15:0] e_comp;
        drive();
        e_req = 1'b0;
        e_abort = 1'b0;
        e_ack = '0;
        e_comp = (!m_busy && !m_locked) ? cfg_comp : m_comp;
        if (rst) begin
            m_busy = 0; m_locked = 0; m_grant = N - 1; m_tx = 8'h00; e_comp = 16'h0000;
        end else if (!cfg_en) begin
            e_abort = m_busy && !next_tx;
            m_busy = 0; m_locked = 0;
        end else if (!m_busy) begin
            w = pick();
            if (w >= 0) begin
                m_tx = dq[w][0];
                e_req = 1'b1;
                e_ack = N'(1) << w;
                m_grant = w;
                m_locked = !lq[w][0];
                m_busy = 1;
            end
        end else if (next_tx) begin
            m_busy = 0;
        end
        m_comp = e_comp;
        if (next_tx) last_nt = cyc;
        @(posedge clk);
        #1;
        cyc++;
        chk("req", req, e_req);
        chk("src_ack", src_ack, e_ack);
        chk("tx_data", tx_data, m_tx);
        chk("busy", busy, m_busy);
        chk("grant_id", grant_id, 3'(m_grant));
        chk("locked", locked, m_locked);
        chk("comp", comp, m_comp);
        chk("abort", abort, e_abort);
        chk("tr_en", tr_en, cfg_en);
        if (gap_chk && req) chk("byte_gap", cyc - last_nt, 2);
        for (int i = 0; i < N; i++) if (src_ack[i]) begin
            ack_log.push_back(i);
            if (dq[i].size() > 0) begin
                void'(dq[i].pop_front());
                void'(lq[i].pop_front());
            end
        end
        nt_pend = 0;
        if (timer > 0) begin
            timer--;
            if (timer == 0) nt_pend = 1;
        end
        if (req) timer = dly;
        if (!cfg_en) timer = 0;
        force_nt = 0;
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((pending() || m_busy) && n < budget) begin
            tick();
            n++;
        end
        chk("idle_within_budget", n < budget, 1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; cfg_en = 1; cfg_comp = 16'h0100; next_tx = 0;
        src_req = '0; src_last = '0; src_data = '0;
        for (int i = 0; i < N; i++) push_byte(i, 8'hA0 + 8'(i), 1);
        push_byte(0, 8'hA4, 1);
        tick();
        tick();
        chk("rst_req", req, 0);
        chk("rst_ack", src_ack, 0);
        chk("rst_comp", comp, 0);
        rst = 0;
        ack_log.delete();
        tick();
        chk("first_grant_src", ack_log.size() > 0 ? ack_log[0] : -1, 0);
        gap_chk = 1;
        run_until_idle(300);
        gap_chk = 0;
        chk("rr_count", ack_log.size(), 5);
        for (int k = 0; k < 5 && k < ack_log.size(); k++) chk("rr_order", ack_log[k], rr_exp[k]);

        ack_log.delete();
        push_byte(2, 8'h11, 0); push_byte(2, 8'h22, 0); push_byte(2, 8'h33, 1);
        push_byte(3, 8'h44, 1);
        tick();
        cfg_comp = 16'h0200;
        tick();
        chk("comp_hold_mid_packet", comp, 16'h0100);
        chk("locked_mid_packet", locked, 1);
        run_until_idle(300);
        chk("pk_count", ack_log.size(), 4);
        for (int k = 0; k < 4 && k < ack_log.size(); k++) chk("pk_order", ack_log[k], pk_exp[k]);
        chk("comp_after_packet", comp, 16'h0200);

        ack_log.delete();
        push_byte(1, 8'h55, 0); push_byte(1, 8'h66, 1);
        push_byte(2, 8'h77, 1);
        tick();
        tick();
        cfg_en = 0;
        tick();
        chk("abort_pulse", abort, 1);
        chk("tr_en_off", tr_en, 0);
        tick();
        chk("abort_once", abort, 0);
        cfg_en = 1;
        tick();
        chk("post_abort_grant", grant_id, 2);
        chk("post_abort_unlocked", locked, 0);
        run_until_idle(300);
        chk("ab_count", ack_log.size(), 3);
        for (int k = 0; k < 3 && k < ack_log.size(); k++) chk("ab_order", ack_log[k], ab_exp[k]);

        push_byte(3, 8'h99, 1);
        tick();
        chk("grant_latency_req", req, 1);
        chk("grant_latency_ack", src_ack, 4'b1000);
        push_byte(0, 8'hAB, 1);
        gap_chk = 1;
        run_until_idle(300);
        gap_chk = 0;

        force_nt = 1;
        tick();
        chk("spurious_busy", busy, 0);
        chk("spurious_req", req, 0);
        tick();
        chk("spurious_req_after", req, 0);

        push_byte(1, 8'hC3, 1);
        tick();
        tick();
        force_nt = 1;
        cfg_en = 0;
        tick();
        chk("simul_next_tx_no_abort", abort, 0);
        cfg_en = 1;
        tick();

        push_byte(2, 8'h5A, 0); push_byte(2, 8'h5B, 1);
        tick();
        tick();
        rst = 1;
        tick();
        chk("midframe_rst_busy", busy, 0);
        chk("midframe_rst_grant", grant_id, 3);
        rst = 0;
        run_until_idle(300);

        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                int s, len;
                s = $urandom_range(0, N - 1);
                len = $urandom_range(1, 3);
                for (int b = 0; b < len; b++) push_byte(s, 8'($urandom), b == len - 1);
            end
            if ($urandom_range(0, 19) == 0) cfg_comp = 16'($urandom);
            if ($urandom_range(0, 29) == 0) dly = $urandom_range(2, 12);
            cfg_en = $urandom_range(0, 39) != 0;
            if ($urandom_range(0, 59) == 0) force_nt = 1;
            tick();
        end
        cfg_en = 1;
        run_until_idle(3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
